uart_io_led_driver: RTL and testbench
=====================================

// Module: uart_io_led_driver
// PURPOSE
//  Downstream of the LED PIO: takes the PIO's 8-bit out_port and drives the board LED pins.
//  Adds a pulse stretcher so one-cycle software writes stay visible.
//  Adds global PWM brightness and per-LED blink.
//  Pure streaming block with no bus interface; brightness and blink_mask come from other PIO regs.
// PARAMETERS
//  WIDTH          8    number of LEDs
//  PRESCALE_DIV   50   clk cycles per tick (>=2)
//  PWM_BITS       4    PWM counter / brightness width
//  STRETCH_TICKS  1000 minimum on-time after led_in falls, in ticks (>=1)
//  BLINK_PERIODS  64   PWM periods per blink half-cycle (>=1)
// PORTS
//  clk         in   1         system clock, single domain
//  reset       in   1         synchronous, active-high
//  led_in      in   WIDTH     logical LED state (PIO out_port)
//  brightness  in   PWM_BITS  duty; 0=off, all-ones=always on
//  blink_mask  in   WIDTH     1 = LED blinks while active
//  led_out     out  WIDTH     registered LED pin drive
//  active      out  WIDTH     registered stretched LED state, before PWM/blink
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset synchronous, active-high.
//  Reset values: prescaler, pwm_cnt, blink_cnt, stretch counters, led_in_q, active and led_out = 0; blink_phase = 1.
//  Prescaler: counts 0..PRESCALE_DIV-1 and wraps. tick = 1 for one cycle when count == PRESCALE_DIV-1.
//  PWM: pwm_cnt increments on tick and wraps at 2^PWM_BITS.
//   pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
//   brightness is sampled every cycle, so a change takes effect the next cycle, mid-period allowed.
//  Blink: pwm_wrap = tick & (pwm_cnt == all-ones).
//   blink_cnt counts pwm_wrap events 0..BLINK_PERIODS-1.
//   On a pwm_wrap with blink_cnt == BLINK_PERIODS-1: blink_cnt <= 0 and blink_phase toggles.
//  Stretch, per bit i (led_in_q = led_in registered once):
//   led_in_q[i]=1: cnt[i] <= STRETCH_TICKS, every cycle.
//   led_in_q[i]=0 and tick and cnt[i]!=0: cnt[i] decrements. cnt[i] saturates at 0.
//   active[i] <= led_in_q[i] | (cnt[i] != 0).
//   A re-rise during stretch reloads the counter; no gap appears in active.
//  Output: led_out[i] <= active_next[i] & pwm_on & (~blink_mask[i] | blink_phase).
//   active_next is the value being written into active this cycle.
//  Latency, led_in rise -> led_out rise: 2 clk (when pwm_on=1 and the LED is not in blink-off phase).
//  Fall: led_out stays high for STRETCH_TICKS ticks after the led_in fall, +/-1 tick for prescaler phase.
//  Simultaneous events:
//   tick and pwm_wrap and blink toggle in the same cycle all take effect together.
//   Decrement in a cycle where led_in_q=1: the reload wins.
//  Reset mid-operation: all state returns to reset values the next cycle; led_out=0 then.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package uart_io_led_pkg holds:
//   the clog2-based width constants for the prescaler, stretch and blink counters;
//   function pwm_full(brightness) that returns the all-ones test.
//  Sub-module uart_io_led_stretch, instanced WIDTH times.
//   Ports: clk, reset, tick, in_q, active_next.
//   Holds the stretch counter and the reload/decrement rule.
//  Top level holds the prescaler, pwm_cnt, blink_cnt/blink_phase, led_in_q and output registers.
// TESTING (bench params: PRESCALE_DIV=4, PWM_BITS=2, STRETCH_TICKS=3, BLINK_PERIODS=2)
//  1. Reset held 3 cycles with led_in=FF, brightness=3 -> led_out=00, active=00 throughout.
//     Release -> led_out=FF 2 clk later.
//  2. brightness=2, led_in=01, blink_mask=00 -> led_out[0] high 8 clk, low 8 clk, period 16 clk.
//     brightness=0 -> led_out=00 constantly.
//  3. led_in=02 for exactly 1 clk, brightness=3 -> active[1] high for 3 ticks (12 +/-4 clk), then 0.
//     led_out[1] tracks active[1].
//  4. led_in[2] pulses again 1 tick into its stretch -> active[2] shows no gap.
//     Low time is measured from the last fall (3 ticks).
//  5. blink_mask=04, led_in=04, brightness=3 -> led_out[2] toggles every 32 clk (2 PWM periods).
//     The other bits are unaffected.
//  6. Assert reset mid-stretch while blink is in the off phase -> next cycle all outputs 0.
//     After release: blink_phase=1, no residual stretch.

Source files
------------

// File: rtl/uart_io_led_pkg.sv
// Shared constants and helpers for the LED driver: counter width sizing
// and the "brightness is full scale" test used by the PWM gate.
package uart_io_led_pkg;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

  // Counter widths for the default build (50-cycle prescaler,
  // 1000-tick stretch, 64-period blink).
  localparam int PRESCALE_W = cnt_width(50 - 1);
  localparam int STRETCH_W  = cnt_width(1000);
  localparam int BLINK_W    = cnt_width(64 - 1);

  // True when the low 'bits' bits of brightness are all ones, i.e. the
  // LED should stay on for the whole PWM period.
  function automatic logic pwm_full(input logic [15:0] brightness, input int bits);
    logic [15:0] ones;
    ones = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) begin
        ones[i] = 1'b1;
      end
    end
    return brightness == ones;
  endfunction

endpackage

// File: rtl/uart_io_led_stretch.sv
// Per-LED pulse stretcher: holds the LED logically on for STRETCH_TICKS
// prescaler ticks after its input falls, so short software pulses stay visible.
module uart_io_led_stretch
  import uart_io_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 1000,
  parameter int CNT_W         = cnt_width(STRETCH_TICKS)
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic in_q,
  output logic active_next
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_TICKS);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Reload while the input is high (reload beats a same-cycle decrement),
  // otherwise count down once per tick and saturate at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (in_q) begin
      cnt_next = RELOAD;
    end else if (tick && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Value the parent writes into its active register this cycle.
  assign active_next = in_q | (cnt_reg != '0);

endmodule

// File: rtl/uart_io_led_driver.sv
// LED pin driver behind the LED PIO: registers led_in, stretches short
// pulses, then applies global PWM brightness and per-LED blink gating.
module uart_io_led_driver
  import uart_io_led_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_DIV  = 50,
  parameter int PWM_BITS      = 4,
  parameter int STRETCH_TICKS = 1000,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [WIDTH-1:0]    blink_mask,
  output logic [WIDTH-1:0]    led_out,
  output logic [WIDTH-1:0]    active
);

  localparam int PRE_W   = cnt_width(PRESCALE_DIV - 1);
  localparam int BLINK_W = cnt_width(BLINK_PERIODS - 1);
  localparam int STR_W   = cnt_width(STRETCH_TICKS);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PRESCALE_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

  logic [PRE_W-1:0]    prescale_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic                blink_phase_reg;
  logic [WIDTH-1:0]    led_in_q_reg;
  logic [WIDTH-1:0]    active_reg;
  logic [WIDTH-1:0]    led_out_reg;

  logic             tick;
  logic             pwm_wrap;
  logic             pwm_on;
  logic [WIDTH-1:0] active_next;
  logic [WIDTH-1:0] blink_gate;

  assign tick       = (prescale_reg == PRE_LAST);
  assign pwm_wrap   = tick & (&pwm_cnt_reg);
  assign pwm_on     = pwm_full(16'(brightness), PWM_BITS) | (pwm_cnt_reg < brightness);
  assign blink_gate = ~blink_mask | {WIDTH{blink_phase_reg}};

  // Prescaler: free-running 0..PRESCALE_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_reg <= '0;
    end else if (tick) begin
      prescale_reg <= '0;
    end else begin
      prescale_reg <= prescale_reg + PRE_W'(1);
    end
  end

  // PWM counter advances once per tick and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  // Blink: count PWM periods, flip phase every BLINK_PERIODS of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (pwm_wrap) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  // One stretcher per LED.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stretch
      uart_io_led_stretch #(
        .STRETCH_TICKS (STRETCH_TICKS),
        .CNT_W         (STR_W)
      ) u_stretch (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .in_q        (led_in_q_reg[gi]),
        .active_next (active_next[gi])
      );
    end
  endgenerate

  // Input capture and output registers; outputs see no combinational input path.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_q_reg <= '0;
      active_reg   <= '0;
      led_out_reg  <= '0;
    end else begin
      led_in_q_reg <= led_in;
      active_reg   <= active_next;
      led_out_reg  <= active_next & {WIDTH{pwm_on}} & blink_gate;
    end
  end

  assign led_out = led_out_reg;
  assign active  = active_reg;

endmodule

// File: tb/tb_uart_io_led_driver.sv
// Directed bench for uart_io_led_driver with small parameters:
// tick every 4 clk, PWM period 16 clk, stretch 3 ticks, blink half-cycle 32 clk.
module tb_uart_io_led_driver;

  logic       clk;
  logic       reset;
  logic [7:0] led_in;
  logic [1:0] brightness;
  logic [7:0] blink_mask;
  logic [7:0] led_out;
  logic [7:0] active;

  int errors = 0;
  int checks = 0;

  uart_io_led_driver #(
    .WIDTH         (8),
    .PRESCALE_DIV  (4),
    .PWM_BITS      (2),
    .STRETCH_TICKS (3),
    .BLINK_PERIODS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .led_out    (led_out),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; led_in = 8'hFF; brightness = 2'd3; blink_mask = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led_out cyc=%0d got=%h exp=00", i, led_out); end
      checks++;
      if (active !== 8'h00) begin errors++; $display("FAIL reset_active cyc=%0d got=%h exp=00", i, active); end
    end
    reset = 1'b0;
    step();
    checks++;
    if (led_out !== 8'h00) begin errors++; $display("FAIL release_1clk got=%h exp=00", led_out); end
    step();
    checks++;
    if (led_out !== 8'hFF) begin errors++; $display("FAIL release_2clk led_out got=%h exp=FF", led_out); end
    checks++;
    if (active !== 8'hFF) begin errors++; $display("FAIL release_2clk active got=%h exp=FF", active); end
    $display("test_reset: led_out=%h active=%h", led_out, active);
  endtask

  task automatic test_pwm();
    logic prev;
    logic seen;
    int   run;
    brightness = 2'd2; led_in = 8'h01; blink_mask = 8'h00;
    seen = 1'b0;
    prev = led_out[0];
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (!prev && led_out[0]) seen = 1'b1;
      prev = led_out[0];
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL pwm_rise got=timeout exp=rise within 40 clk");
    end else begin
      run = 1;
      while (run < 20) begin
        step();
        if (!led_out[0]) break;
        run++;
      end
      checks++;
      if (run !== 8) begin errors++; $display("FAIL pwm_high_len got=%0d exp=8", run); end
      run = 1;
      while (run < 20) begin
        step();
        if (led_out[0]) break;
        run++;
      end
      checks++;
      if (run !== 8) begin errors++; $display("FAIL pwm_low_len got=%0d exp=8", run); end
      $display("test_pwm: brightness=2 low run=%0d", run);
    end
    brightness = 2'd0;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (led_out !== 8'h00) begin errors++; $display("FAIL pwm_zero cyc=%0d got=%h exp=00", i, led_out); end
    end
    $display("test_pwm: brightness=0 led_out=%h", led_out);
  endtask

  task automatic settle_idle();
    led_in = 8'h00; brightness = 2'd3; blink_mask = 8'h00;
    repeat (30) step();
    checks++;
    if (active !== 8'h00) begin errors++; $display("FAIL idle_active got=%h exp=00", active); end
  endtask

  task automatic test_stretch();
    int run;
    led_in = 8'h02;
    step();
    led_in = 8'h00;
    checks++;
    if (active[1] !== 1'b0) begin errors++; $display("FAIL stretch_1clk got=%b exp=0", active[1]); end
    step();
    checks++;
    if (active[1] !== 1'b1) begin errors++; $display("FAIL stretch_2clk got=%b exp=1", active[1]); end
    run = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (led_out[1] !== active[1]) begin errors++; $display("FAIL stretch_track cyc=%0d got=%b exp=%b", i, led_out[1], active[1]); end
      if (!active[1]) break;
      run++;
    end
    // 3 ticks after the fall, first tick lands 0..3 clk after the counter loads.
    checks++;
    if (run < 10 || run > 13) begin errors++; $display("FAIL stretch_len got=%0d exp=10..13", run); end
    repeat (4) step();
    checks++;
    if (active !== 8'h00) begin errors++; $display("FAIL stretch_after got=%h exp=00", active); end
    $display("test_stretch: active[1] high %0d clk", run);
  endtask

  task automatic test_back_to_back();
    int run;
    led_in = 8'h04;
    step();
    led_in = 8'h00;
    step();
    checks++;
    if (active[2] !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b exp=1", active[2]); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (active[2] !== 1'b1) begin errors++; $display("FAIL b2b_gap_a cyc=%0d got=%b exp=1", i, active[2]); end
    end
    led_in = 8'h04;
    step();
    led_in = 8'h00;
    checks++;
    if (active[2] !== 1'b1) begin errors++; $display("FAIL b2b_gap_b got=%b exp=1", active[2]); end
    step();
    checks++;
    if (active[2] !== 1'b1) begin errors++; $display("FAIL b2b_gap_c got=%b exp=1", active[2]); end
    run = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!active[2]) break;
      run++;
    end
    checks++;
    if (run < 10 || run > 13) begin errors++; $display("FAIL b2b_len got=%0d exp=10..13", run); end
    $display("test_back_to_back: active[2] high %0d clk after last pulse", run);
  endtask

  task automatic test_blink();
    logic prev;
    logic seen;
    int   run;
    blink_mask = 8'h04; led_in = 8'h0C; brightness = 2'd3;
    repeat (4) step();
    seen = 1'b0;
    prev = led_out[2];
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (led_out[2] !== prev) seen = 1'b1;
      prev = led_out[2];
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL blink_edge got=timeout exp=toggle within 80 clk");
    end else begin
      for (int r = 0; r < 2; r++) begin
        run = 1;
        while (run < 40) begin
          step();
          checks++;
          if ((led_out & 8'hFB) !== 8'h08) begin errors++; $display("FAIL blink_others got=%h exp=08", led_out & 8'hFB); end
          if (led_out[2] !== prev) break;
          run++;
        end
        prev = led_out[2];
        checks++;
        if (run !== 32) begin errors++; $display("FAIL blink_run%0d got=%0d exp=32", r, run); end
        $display("test_blink: run %0d length %0d", r, run);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic prev;
    logic seen;
    seen = 1'b0;
    prev = led_out[2];
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (prev && !led_out[2]) seen = 1'b1;
      prev = led_out[2];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_blink_off got=timeout exp=fall within 80 clk"); end
    led_in = 8'h00;
    step();
    step();
    checks++;
    if (active !== 8'h0C) begin errors++; $display("FAIL midrst_stretching got=%h exp=0C", active); end
    reset = 1'b1;
    step();
    checks++;
    if (led_out !== 8'h00) begin errors++; $display("FAIL midrst_led_out got=%h exp=00", led_out); end
    checks++;
    if (active !== 8'h00) begin errors++; $display("FAIL midrst_active got=%h exp=00", active); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (active !== 8'h00) begin errors++; $display("FAIL midrst_residual cyc=%0d got=%h exp=00", i, active); end
    end
    led_in = 8'h04;
    step();
    step();
    checks++;
    if (led_out !== 8'h04) begin errors++; $display("FAIL midrst_phase got=%h exp=04", led_out); end
    $display("test_reset_mid: led_out=%h after release", led_out);
  endtask

  initial begin
    test_reset();
    test_pwm();
    settle_idle();
    test_stretch();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
